// File: rtl/rtc_refresh_sequencer.sv
// Periodic RTC snapshot reader: nine bus reads into shadow registers,
// then a one-cycle 8'hFF commit strobe for the display latch.
module rtc_refresh_sequencer #(
  parameter int         TIMEOUT_CYC = 255,
  parameter logic [7:0] ADDR_BASE_T = 8'h21,
  parameter logic [7:0] ADDR_BASE_C = 8'h41
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       prog_busy,
  input  logic       bus_ack,
  input  logic [7:0] bus_rdata,
  output logic       bus_req,
  output logic [7:0] bus_addr,
  output logic [7:0] handshake,
  output logic [7:0] s_oro,
  output logic [7:0] m_oro,
  output logic [7:0] h_oro,
  output logic [7:0] giorno,
  output logic [7:0] messe,
  output logic [7:0] agno,
  output logic [7:0] secondo,
  output logic [7:0] minute,
  output logic [7:0] ora,
  output logic       busy,
  output logic       err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    NEXT,
    COMMIT
  } state_t;

  state_t          r_st;
  state_t          w_nx;
  logic [3:0]      r_idx;
  logic [3:0]      w_idx_nx;
  logic            r_pend;
  logic [CW-1:0]   r_cnt;
  logic            w_ack_ok;
  logic            w_tmo;
  logic [7:0]      r_sh [9];

  function automatic logic [7:0] f_addr(input logic [3:0] i);
    if (i < 4'd6)
      return ADDR_BASE_T + {4'b0, i};
    else
      return ADDR_BASE_C + {4'b0, i} - 8'd6;
  endfunction

  always_comb begin
    w_nx     = r_st;
    w_idx_nx = r_idx;
    w_ack_ok = 1'b0;
    w_tmo    = 1'b0;
    unique case (r_st)
      IDLE: begin
        if ((refresh_tick || r_pend) && !prog_busy) begin
          w_nx     = ISSUE;
          w_idx_nx = 4'd0;
        end
      end
      ISSUE: w_nx = WAIT_ACK;
      WAIT_ACK: begin
        if (bus_ack) begin
          w_nx     = NEXT;
          w_ack_ok = 1'b1;
        end else if (r_cnt == TLAST) begin
          w_nx  = IDLE;
          w_tmo = 1'b1;
        end
      end
      NEXT: begin
        // prog_busy aborts only here, at a register boundary
        if (prog_busy) begin
          w_nx = IDLE;
        end else if (r_idx == 4'd8) begin
          w_nx = COMMIT;
        end else begin
          w_nx     = ISSUE;
          w_idx_nx = r_idx + 4'd1;
        end
      end
      COMMIT:  w_nx = IDLE;
      default: w_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_st      <= IDLE;
      r_idx     <= 4'd0;
      r_pend    <= 1'b0;
      r_cnt     <= '0;
      bus_req   <= 1'b0;
      bus_addr  <= 8'h00;
      handshake <= 8'h00;
      busy      <= 1'b0;
      err       <= 1'b0;
      for (int k = 0; k < 9; k++) r_sh[k] <= 8'h00;
    end else begin
      r_st   <= w_nx;
      r_idx  <= w_idx_nx;
      r_pend <= (r_st == IDLE && w_nx == ISSUE) ? 1'b0
                                                : (r_pend | refresh_tick);
      r_cnt  <= (r_st == WAIT_ACK) ? r_cnt + CW'(1) : '0;
      // outputs are registered from next state so they line up with it
      bus_req   <= (w_nx == ISSUE) || (w_nx == WAIT_ACK);
      if (w_nx == ISSUE) bus_addr <= f_addr(w_idx_nx);
      handshake <= (w_nx == COMMIT) ? 8'hFF : 8'h00;
      busy      <= (w_nx != IDLE);
      err       <= w_tmo;
      if (w_ack_ok) r_sh[r_idx] <= bus_rdata;
    end
  end

  assign s_oro   = r_sh[0];
  assign m_oro   = r_sh[1];
  assign h_oro   = r_sh[2];
  assign giorno  = r_sh[3];
  assign messe   = r_sh[4];
  assign agno    = r_sh[5];
  assign secondo = r_sh[6];
  assign minute  = r_sh[7];
  assign ora     = r_sh[8];

endmodule

// File: tb/tb_rtc_refresh_sequencer.sv
// Bench for rtc_refresh_sequencer: bus responder, transaction-level
// model of the expected shadows/addresses, and directed scenarios.
module tb_rtc_refresh_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       refresh_tick = 1'b0;
  logic       prog_busy = 1'b0;
  logic       bus_ack = 1'b0;
  logic [7:0] bus_rdata = 8'h00;
  logic       bus_req;
  logic [7:0] bus_addr;
  logic [7:0] handshake;
  logic [7:0] s_oro, m_oro, h_oro, giorno, messe, agno;
  logic [7:0] secondo, minute, ora;
  logic       busy;
  logic       err;

  rtc_refresh_sequencer dut (
    .clock(clock), .reset(reset), .refresh_tick(refresh_tick),
    .prog_busy(prog_busy), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_req(bus_req), .bus_addr(bus_addr), .handshake(handshake),
    .s_oro(s_oro), .m_oro(m_oro), .h_oro(h_oro),
    .giorno(giorno), .messe(messe), .agno(agno),
    .secondo(secondo), .minute(minute), .ora(ora),
    .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err = 0;

  logic [7:0] data_base = 8'h10;
  logic       drop_en = 1'b0;
  int         drop_idx = 0;
  logic       spur_ack = 1'b0;
  logic       resp_ack = 1'b0;
  int         resp_idx = 0;
  logic [7:0] resp_data = 8'h00;

  logic [7:0] exp_sh [9];
  int         m_idx = 0;
  int         hs_count = 0;
  int         err_count = 0;
  logic [7:0] addr_log [$];

  task automatic chk(input string name, input logic [71:0] act,
                     input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int addr2idx(input logic [7:0] a);
    if (a >= 8'h21 && a <= 8'h26) return int'(a) - 'h21;
    if (a >= 8'h41 && a <= 8'h43) return int'(a) - 'h41 + 6;
    return 15;
  endfunction

  function automatic logic [7:0] addr_of(input int i);
    if (i < 6) return 8'(8'h21 + i);
    return 8'(8'h41 + i - 6);
  endfunction

  function automatic logic [71:0] dut_sh();
    return {s_oro, m_oro, h_oro, giorno, messe, agno, secondo, minute, ora};
  endfunction

  function automatic logic [71:0] model_sh();
    logic [71:0] v;
    v = '0;
    for (int k = 0; k < 9; k++) v = {v[63:0], exp_sh[k]};
    return v;
  endfunction

  function automatic logic [71:0] log_pack(input int first);
    logic [71:0] v;
    v = '0;
    for (int k = first; k < first + 9; k++)
      v = {v[63:0], (k < addr_log.size()) ? addr_log[k] : 8'h00};
    return v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 9; k++) exp_sh[k] = 8'h00;
    m_idx = 0;
  endtask

  // Bus responder: acks in the first WAIT_ACK cycle of each request
  initial begin
    logic seen, given;
    seen = 0;
    given = 0;
    forever begin
      @(negedge clock);
      resp_ack = 1'b0;
      if (reset) begin
        seen = 0;
        given = 0;
      end else if (bus_req) begin
        if (seen && !given &&
            !(drop_en && addr2idx(bus_addr) == drop_idx)) begin
          resp_ack  = 1'b1;
          resp_idx  = addr2idx(bus_addr);
          resp_data = data_base + 8'(resp_idx);
          given = 1;
        end
        seen = 1;
      end else begin
        seen = 0;
        given = 0;
      end
      bus_ack   = resp_ack | spur_ack;
      bus_rdata = spur_ack ? 8'hEE : (resp_ack ? resp_data : 8'h00);
      spur_ack  = 1'b0;
    end
  end

  // Model update: an accepted read lands in the shadow it addressed
  initial begin
    forever begin
      @(posedge clock);
      if (!reset && resp_ack && resp_idx < 9) begin
        exp_sh[resp_idx] = resp_data;
        m_idx++;
      end
    end
  end

  // Per-cycle compare against the model
  initial begin
    logic       prev_req;
    logic [7:0] prev_addr;
    prev_req = 0;
    prev_addr = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_req = 0;
      end else begin
        chk("shadows", dut_sh(), model_sh());
        if (!busy) chk("req_idle", {71'b0, bus_req}, 72'd0);
        if (bus_req && !prev_req) begin
          chk("addr", {64'b0, bus_addr}, {64'b0, addr_of(m_idx)});
          addr_log.push_back(bus_addr);
        end else if (bus_req) begin
          chk("addr_stable", {64'b0, bus_addr}, {64'b0, prev_addr});
        end
        if (handshake != 8'h00) begin
          chk("hs_value", {64'b0, handshake}, 72'hFF);
          chk("hs_complete", 72'(m_idx), 72'd9);
          m_idx = 0;
          hs_count++;
        end
        if (err) begin
          err_count++;
          m_idx = 0;
        end
        prev_req  = bus_req;
        prev_addr = bus_addr;
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    refresh_tick = 1'b1;
    @(negedge clock);
    refresh_tick = 1'b0;
  endtask

  task automatic wait_addr(input logic [7:0] a);
    int n;
    n = 0;
    while (!(bus_req && bus_addr == a) && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (n >= 400) chk("wait_addr_timeout", 72'd1, 72'd0);
  endtask

  task automatic wait_hs();
    int n;
    n = 0;
    while (handshake != 8'hFF && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) chk("wait_hs_timeout", 72'd1, 72'd0);
    @(negedge clock);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || bus_req) && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (n >= 400) chk("wait_idle_timeout", 72'd1, 72'd0);
  endtask

  initial begin
    int hs0, hs_cyc, reqc, n;
    model_clear();
    repeat (3) @(negedge clock);
    chk("rst_req", {71'b0, bus_req}, 72'd0);
    chk("rst_ctl", {62'b0, busy, err, handshake}, 72'd0);
    chk("rst_addr", {64'b0, bus_addr}, 72'd0);
    chk("rst_sh", dut_sh(), 72'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // basic read, zero-wait ack
    data_base = 8'h10;
    addr_log.delete();
    hs0 = hs_count;
    tick();
    hs_cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      if (handshake == 8'hFF && hs_cyc == 0) hs_cyc = c;
      @(negedge clock);
    end
    chk("hs_cycle", 72'(hs_cyc), 72'd28);
    chk("addr_order", log_pack(0), 72'h212223242526414243);
    chk("basic_sh", dut_sh(), 72'h101112131415161718);
    chk("basic_hs_n", 72'(hs_count - hs0), 72'd1);
    chk("basic_busy", {71'b0, busy}, 72'd0);

    // ticks during a sequence give exactly one more
    addr_log.delete();
    hs0 = hs_count;
    tick();
    repeat (5) @(negedge clock);
    tick();
    repeat (10) @(negedge clock);
    tick();
    repeat (120) @(negedge clock);
    chk("dbl_hs_n", 72'(hs_count - hs0), 72'd2);
    chk("dbl_reads", 72'(addr_log.size()), 72'd18);
    chk("dbl_busy", {71'b0, busy}, 72'd0);

    // prog_busy abort at idx 4, pending held until release
    data_base = 8'h30;
    addr_log.delete();
    hs0 = hs_count;
    tick();
    wait_addr(8'h25);
    prog_busy = 1'b1;
    repeat (3) @(negedge clock);
    chk("abort_busy", {71'b0, busy}, 72'd0);
    m_idx = 0;
    tick();
    reqc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (bus_req || busy) reqc++;
    end
    chk("abort_hold", 72'(reqc), 72'd0);
    chk("abort_sh", dut_sh(), 72'h303132333415161718);
    chk("abort_hs_n", 72'(hs_count - hs0), 72'd0);
    chk("abort_reads", 72'(addr_log.size()), 72'd5);
    prog_busy = 1'b0;
    wait_hs();
    chk("resume_sh", dut_sh(), 72'h303132333435363738);
    chk("resume_addr", log_pack(5), 72'h212223242526414243);

    // timeout at idx 2
    wait_idle();
    data_base = 8'h50;
    drop_en = 1'b1;
    drop_idx = 2;
    hs0 = hs_count;
    tick();
    wait_addr(8'h23);
    n = 1;
    @(negedge clock);
    while (bus_req && n < 400) begin
      n++;
      @(negedge clock);
    end
    chk("tmo_req_cycles", 72'(n), 72'd256);
    chk("tmo_err", {71'b0, err}, 72'd1);
    @(negedge clock);
    chk("tmo_err_pulse", {71'b0, err}, 72'd0);
    chk("tmo_sh", dut_sh(), 72'h505132333435363738);
    chk("tmo_hs_n", 72'(hs_count - hs0), 72'd0);
    drop_en = 1'b0;
    addr_log.delete();
    tick();
    wait_hs();
    chk("tmo_restart", log_pack(0), 72'h212223242526414243);
    chk("tmo_after_sh", dut_sh(), 72'h505152535455565758);

    // reset in WAIT_ACK at idx 7
    wait_idle();
    drop_en = 1'b1;
    drop_idx = 7;
    tick();
    wait_addr(8'h42);
    @(negedge clock);
    reset = 1'b1;
    model_clear();
    #1;
    chk("mrst_req", {71'b0, bus_req}, 72'd0);
    chk("mrst_ctl", {54'b0, busy, err, handshake, bus_addr}, 72'd0);
    chk("mrst_sh", dut_sh(), 72'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    drop_en = 1'b0;
    data_base = 8'h60;
    addr_log.delete();
    hs0 = hs_count;
    tick();
    wait_hs();
    chk("mrst_full", log_pack(0), 72'h212223242526414243);
    chk("mrst_after_sh", dut_sh(), 72'h606162636465666768);
    chk("mrst_hs_n", 72'(hs_count - hs0), 72'd1);

    // spurious ack in IDLE
    wait_idle();
    n = addr_log.size();
    spur_ack = 1'b1;
    repeat (5) @(negedge clock);
    chk("spur_busy", {70'b0, busy, bus_req}, 72'd0);
    chk("spur_sh", dut_sh(), 72'h606162636465666768);
    chk("spur_reads", 72'(addr_log.size() - n), 72'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
